controle_fluxo_agua_param: RTL
==============================

Name: controle_fluxo_agua_param

Overview:
- Parametrised tank-fill controller. Reads N_SENS level sensors as a thermometer code and drives one inlet valve.
- Synchronises and debounces the sensors, applies hysteresis between LOW_LVL and HIGH_LVL, and detects two faults: an invalid sensor pattern and a fill with no progress.
- Sits between the raw sensor pins and the valve driver in the water-control datapath.

Parameters:
- N_SENS, 4, number of level sensors (bit i = water at or above sensor i); 2..15.
- DEB_CYCLES, 8, consecutive stable samples needed to accept a new sensor vector; >=1.
- TIMEOUT_CYCLES, 1000, maximum cycles in FILL without a level increase before a fault; >=2.
- LOW_LVL, 1, filling starts when level < LOW_LVL; 1 <= LOW_LVL < HIGH_LVL.
- HIGH_LVL, 4, filling stops when level >= HIGH_LVL; HIGH_LVL <= N_SENS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- enable  in  1  controller enable.
- sensor  in  N_SENS  raw asynchronous level sensors.
- fault_clr  in  1  one-cycle fault acknowledge.
- valve  out  1  1 = inlet valve open.
- level  out  clog2(N_SENS+1)  debounced level (popcount of the accepted vector).
- state  out  2  FSM state: 00 IDLE, 01 FILL, 10 FULL, 11 FAULT.
- fault_code  out  2  00 none, 01 invalid sensor pattern, 10 fill timeout.

Behaviour:
- Reset (rst_n=0, async): all of the following clear to 0: synchroniser flops, accepted vector sens_q, debounce counter, timeout counter, level, state (IDLE), valve, fault_code. Release is sampled on the next clk edge.
- Sync: sensor passes through 2 flops per bit, giving sens_s.
- Debounce:
  - Counter clears whenever sens_s differs from its previous sample; otherwise it increments, saturating at DEB_CYCLES.
  - sens_q <= sens_s on the edge where the counter reaches DEB_CYCLES.
  - Glitches shorter than DEB_CYCLES cycles never reach sens_q.
- Valid pattern: sens_q == 2^k-1 for some k in 0..N_SENS; then level = k.
  - If the pattern is invalid, level holds its last valid value.
- Latency: raw sensor step to state/valve change = 2 + DEB_CYCLES + 1 clk edges.
- All outputs are registered. valve = 1 exactly when state == FILL.
- FSM rules, evaluated each edge in priority order:
  1. Invalid sens_q in any state except FAULT -> FAULT, fault_code=01.
  2. In FILL, timeout counter reaches TIMEOUT_CYCLES -> FAULT, fault_code=10.
  3. enable=0 in IDLE, FILL or FULL -> IDLE.
  4. Level transitions:
     - IDLE -> FILL when enable=1 and level < LOW_LVL.
     - FILL -> FULL when level >= HIGH_LVL.
     - FULL -> FILL when enable=1 and level < LOW_LVL.
     - Otherwise hold state (hysteresis band).
- Timeout counter:
  - Clears on entry to FILL and on every edge where level increases.
  - Increments each cycle in FILL; width clog2(TIMEOUT_CYCLES+1).
  - Held at 0 outside FILL.
- FAULT:
  - valve=0.
  - Exit to IDLE only when fault_clr=1 and sens_q is valid; fault_code clears to 00 on that exit.
  - fault_clr with an invalid pattern is ignored; state stays FAULT and fault_code is unchanged.
  - fault_clr outside FAULT has no effect.
- Simultaneous events:
  - Invalid pattern beats timeout; timeout beats enable=0.
  - If level jumps to >= HIGH_LVL on the same edge the timeout would expire, the level increase clears the timer, so the result is FULL.

Optional Feature:
- Macro: CONTROLE_FLUXO_FILL_COUNT_EN.
- When defined:
  - Extra output fill_count, out, 16 bits.
  - Counts FILL->FULL transitions, saturating at 16'hFFFF.
  - Cleared by reset; unaffected by faults or fault_clr.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Params N_SENS=4, DEB_CYCLES=4, TIMEOUT_CYCLES=20, LOW_LVL=1, HIGH_LVL=4. Reset, enable=1, sensor=0000 -> state=01 and valve=1 within 2+4+1 edges of reset release; level=0.
- Step sensor 0001, 0011, 0111, 1111, each held 10 cycles -> level 1,2,3,4; state=10 and valve=0 seven edges after 1111 applied. Then step 1111 -> 0001 -> state stays 10 (level=1, not < LOW_LVL). Then 0000 -> state=01, valve=1.
- In FILL, toggle sensor 0000 <-> 0001 with 2-cycle pulses -> level stays 0, state stays 01 until the timeout: state=11, fault_code=10 at 20 cycles after FILL entry.
- Apply sensor=0101 held 10 cycles -> state=11, fault_code=01, valve=0. fault_clr pulse while 0101 -> still 11. Sensor=0011 stable, then fault_clr -> state=00, fault_code=00.
- Assert rst_n=0 mid-FILL, between clock edges -> valve, state, level and fault_code go to 0 immediately, without waiting for an edge.
- With CONTROLE_FLUXO_FILL_COUNT_EN defined: three complete fill cycles -> fill_count=3. Preload the counter to 16'hFFFF and complete one more fill -> fill_count stays 16'hFFFF.

Source files
------------

// File: rtl/controle_fluxo_agua_param.sv
// -----------------------------------------------------------------------------
// controle_fluxo_agua_param
//
// Tank-fill controller. Takes N_SENS raw level sensors (thermometer code, bit i
// set = water at or above sensor i), synchronises and debounces them, and drives
// a single inlet valve with hysteresis between LOW_LVL and HIGH_LVL. Flags an
// invalid sensor pattern and a fill that makes no progress for TIMEOUT_CYCLES.
//
// Ports:
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   enable      in   1        controller enable
//   sensor      in   N_SENS   raw asynchronous level sensors
//   fault_clr   in   1        one-cycle fault acknowledge
//   valve       out  1        1 = inlet valve open (registered, = state FILL)
//   level       out  LVL_W    debounced level, popcount of accepted vector
//   state       out  2        00 IDLE, 01 FILL, 10 FULL, 11 FAULT
//   fault_code  out  2        00 none, 01 invalid pattern, 10 fill timeout
//   fill_count  out  16       FILL->FULL count, saturating (only when
//                             CONTROLE_FLUXO_FILL_COUNT_EN is defined)
//
// Optional feature macro: CONTROLE_FLUXO_FILL_COUNT_EN
//
// Interface handshake: there is no valid/ready pair on this block. fault_clr is
// a plain level sampled on every rising edge; it only acts in FAULT with a
// valid accepted sensor vector, and is ignored everywhere else.
// The state output doubles as the debug view of the FSM.
// -----------------------------------------------------------------------------
module controle_fluxo_agua_param #(
   parameter int N_SENS         = 4,
   parameter int DEB_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int LOW_LVL        = 1,
   parameter int HIGH_LVL       = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [N_SENS-1:0]             sensor,
   input  logic                          fault_clr,
   output logic                          valve,
   output logic [$clog2(N_SENS+1)-1:0]   level,
   output logic [1:0]                    state,
   output logic [1:0]                    fault_code
`ifdef CONTROLE_FLUXO_FILL_COUNT_EN
   ,
   output logic [15:0]                   fill_count
`endif
);

   localparam int LVL_W = $clog2(N_SENS + 1);
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FILL  = 2'b01,
      ST_FULL  = 2'b10,
      ST_FAULT = 2'b11
   } state_t;

   // A thermometer code 2^k-1 is the only pattern where v & (v+1) is zero;
   // the all-ones vector wraps v+1 to zero and is accepted as well.
   function automatic logic is_thermo(input logic [N_SENS-1:0] v);
      logic [N_SENS-1:0] v_inc;
      v_inc = v + 1'b1;
      return ((v & v_inc) == '0);
   endfunction

   function automatic logic [LVL_W-1:0] popcount(input logic [N_SENS-1:0] v);
      logic [LVL_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < N_SENS; i++) begin
         cnt = cnt + LVL_W'(v[i]);
      end
      return cnt;
   endfunction

   logic [N_SENS-1:0] r_sync1;
   logic [N_SENS-1:0] r_sync2;
   logic [N_SENS-1:0] r_sens_q;
   logic [DEB_W-1:0]  r_deb_cnt;
   logic [TMO_W-1:0]  r_tmo;
   logic [LVL_W-1:0]  r_level;
   state_t            r_state;
   logic              r_valve;
   logic [1:0]        r_fault_code;

   logic [DEB_W-1:0]  w_deb_nxt;
   logic              w_deb_hit;
   logic [LVL_W-1:0]  w_level_nxt;
   logic              w_lvl_up;
   logic              w_q_valid;
   logic [TMO_W-1:0]  w_tmo_inc;
   logic              w_tmo_exp;
   logic [TMO_W-1:0]  w_tmo_d;
   state_t            w_state_nxt;
   logic [1:0]        w_code_nxt;

   // ---------------------------------------------------------------------------
   // Debounce. r_sync1 is the sample about to enter r_sync2 (sens_s), so
   // comparing the two tells whether sens_s is about to change. The vector is
   // accepted on the edge the run counter reaches DEB_CYCLES, which together
   // with the two sync stages and the registered FSM gives a step-to-valve
   // latency of 2 + DEB_CYCLES + 1 edges.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_deb_nxt = r_deb_cnt;
      if (r_sync1 != r_sync2) begin
         w_deb_nxt = '0;
      end else if (r_deb_cnt != DEB_W'(DEB_CYCLES)) begin
         w_deb_nxt = r_deb_cnt + 1'b1;
      end
   end

   assign w_deb_hit = (w_deb_nxt == DEB_W'(DEB_CYCLES));

   // Level follows the accepted vector only while that vector is a valid
   // thermometer code; otherwise it keeps the last valid value.
   always_comb begin
      w_level_nxt = r_level;
      if (w_deb_hit && is_thermo(r_sync2)) begin
         w_level_nxt = popcount(r_sync2);
      end
   end

   assign w_lvl_up  = (w_level_nxt > r_level);
   assign w_q_valid = is_thermo(r_sens_q);

   // A level increase on this edge restarts the no-progress timer, and it wins
   // over an expiry landing on the same edge.
   assign w_tmo_inc = w_lvl_up ? '0 : (r_tmo + 1'b1);
   assign w_tmo_exp = (w_tmo_inc == TMO_W'(TIMEOUT_CYCLES));

   // ---------------------------------------------------------------------------
   // FSM next state, priority: invalid pattern, timeout, enable low, level.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_fault_code;
      if (r_state == ST_FAULT) begin
         if (fault_clr && w_q_valid) begin
            w_state_nxt = ST_IDLE;
            w_code_nxt  = 2'b00;
         end
      end else if (!w_q_valid) begin
         w_state_nxt = ST_FAULT;
         w_code_nxt  = 2'b01;
      end else if ((r_state == ST_FILL) && w_tmo_exp) begin
         w_state_nxt = ST_FAULT;
         w_code_nxt  = 2'b10;
      end else if (!enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (r_level <  LVL_W'(LOW_LVL))  w_state_nxt = ST_FILL;
            ST_FILL: if (r_level >= LVL_W'(HIGH_LVL)) w_state_nxt = ST_FULL;
            ST_FULL: if (r_level <  LVL_W'(LOW_LVL))  w_state_nxt = ST_FILL;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // Timer restarts on entry to FILL and stays at zero outside FILL.
   always_comb begin
      w_tmo_d = '0;
      if ((w_state_nxt == ST_FILL) && (r_state == ST_FILL)) begin
         w_tmo_d = w_tmo_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_sens_q     <= '0;
         r_deb_cnt    <= '0;
         r_tmo        <= '0;
         r_level      <= '0;
         r_state      <= ST_IDLE;
         r_valve      <= 1'b0;
         r_fault_code <= 2'b00;
      end else begin
         r_sync1      <= sensor;
         r_sync2      <= r_sync1;
         r_deb_cnt    <= w_deb_nxt;
         if (w_deb_hit) begin
            r_sens_q <= r_sync2;
         end
         r_level      <= w_level_nxt;
         r_tmo        <= w_tmo_d;
         r_state      <= w_state_nxt;
         r_valve      <= (w_state_nxt == ST_FILL);
         r_fault_code <= w_code_nxt;
      end
   end

   assign valve      = r_valve;
   assign level      = r_level;
   assign state      = r_state;
   assign fault_code = r_fault_code;

`ifdef CONTROLE_FLUXO_FILL_COUNT_EN
   // Completed fills; faults and fault_clr leave it alone.
   logic [15:0] r_fill_count;
   logic        w_fill_done;

   assign w_fill_done = (r_state == ST_FILL) && (w_state_nxt == ST_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill_count <= '0;
      end else if (w_fill_done && (r_fill_count != 16'hFFFF)) begin
         r_fill_count <= r_fill_count + 16'd1;
      end
   end

   assign fill_count = r_fill_count;
`else
   // Fill counter not built in this configuration.
`endif

endmodule
